// File: rtl/axi_lite_arb_2to1_if.sv
// rtl/axi_lite_arb_2to1_if.sv - AXI-Lite bus bundle used on both arbiter sides
interface axi_lite_inf #(
   parameter int ASIZE = 32,
   parameter int DSIZE = 32
);
   logic               awvalid;
   logic               awready;
   logic [ASIZE-1:0]   awaddr;
   logic               wvalid;
   logic               wready;
   logic [DSIZE-1:0]   wdata;
   logic [DSIZE/8-1:0] wstrb;
   logic               bvalid;
   logic               bready;
   logic [1:0]         bresp;
   logic               arvalid;
   logic               arready;
   logic [ASIZE-1:0]   araddr;
   logic               rvalid;
   logic               rready;
   logic [DSIZE-1:0]   rdata;
   logic [1:0]         rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slaver (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_arb_2to1.sv
// rtl/axi_lite_arb_2to1.sv - round-robin 2:1 AXI-Lite arbiter, one transaction in flight
// Optional watchdog with SLVERR completion: define AXIL_ARB_TIMEOUT_EN.
module axi_lite_arb_2to1 #(
   parameter int ASIZE          = 32,
   parameter int DSIZE          = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        axi_lite_aclk,
   input  logic        axi_lite_reset,
   axi_lite_inf.slaver m0,
   axi_lite_inf.slaver m1,
   axi_lite_inf.master s,
   output logic [1:0]  grant,
   output logic        timeout
);

`ifdef AXIL_ARB_TIMEOUT_EN
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ERR_RESP} state_t;
`else
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;
`endif

   state_t           state_q, state_d;
   logic             owner, rr_ptr, is_wr;
   logic             aw_done, w_done, aw_hs, w_hs, done;
   logic             req0, req1, win, win_aw;
   logic             sel_awvalid, sel_wvalid, sel_arvalid, sel_bready, sel_rready;
   logic [ASIZE-1:0] sel_awaddr, sel_araddr;
   logic             up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
   logic [1:0]       up_bresp, up_rresp;
   logic [DSIZE-1:0] up_rdata;

   assign req0   = m0.awvalid | m0.arvalid;
   assign req1   = m1.awvalid | m1.arvalid;
   assign win    = (req0 & req1) ? rr_ptr : req1;
   assign win_aw = win ? m1.awvalid : m0.awvalid;

   assign sel_awvalid = owner ? m1.awvalid : m0.awvalid;
   assign sel_wvalid  = owner ? m1.wvalid  : m0.wvalid;
   assign sel_arvalid = owner ? m1.arvalid : m0.arvalid;
   assign sel_bready  = owner ? m1.bready  : m0.bready;
   assign sel_rready  = owner ? m1.rready  : m0.rready;
   assign sel_awaddr  = owner ? m1.awaddr  : m0.awaddr;
   assign sel_araddr  = owner ? m1.araddr  : m0.araddr;

   assign s.awaddr = sel_awaddr;
   assign s.araddr = sel_araddr;
   assign s.wdata  = owner ? m1.wdata : m0.wdata;
   assign s.wstrb  = owner ? m1.wstrb : m0.wstrb;

   assign grant = (state_q == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

`ifdef AXIL_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;
   logic          tmo_active, tmo_hit, tmo_q, drain_q;

   assign tmo_active = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_RESP);
   // The expiry cycle itself forwards nothing, so no handshake can race the abort.
   assign tmo_hit    = tmo_active && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
   assign timeout    = tmo_q;

   always_ff @(posedge axi_lite_aclk or posedge axi_lite_reset) begin
      if (axi_lite_reset) begin
         tmo_cnt <= '0;
         tmo_q   <= 1'b0;
         drain_q <= 1'b0;
      end else begin
         tmo_cnt <= (tmo_active && state_d == state_q) ? tmo_cnt + CW'(1) : '0;
         tmo_q   <= tmo_hit;
         drain_q <= (state_q == ERR_RESP) && (state_d == IDLE);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge axi_lite_aclk or posedge axi_lite_reset) begin
      if (axi_lite_reset) state_q <= IDLE;
      else                state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      done       = 1'b0;
      aw_hs      = 1'b0;
      w_hs       = 1'b0;
      s.awvalid  = 1'b0;
      s.wvalid   = 1'b0;
      s.bready   = 1'b0;
      s.arvalid  = 1'b0;
      s.rready   = 1'b0;
      up_awready = 1'b0;
      up_wready  = 1'b0;
      up_bvalid  = 1'b0;
      up_arready = 1'b0;
      up_rvalid  = 1'b0;
      up_bresp   = s.bresp;
      up_rresp   = s.rresp;
      up_rdata   = s.rdata;
      case (state_q)
         IDLE: begin
`ifdef AXIL_ARB_TIMEOUT_EN
            s.bready = drain_q;
            s.rready = drain_q;
`endif
            if (req0 | req1) state_d = win_aw ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            s.awvalid  = sel_awvalid & ~aw_done;
            up_awready = s.awready & ~aw_done;
            s.wvalid   = sel_wvalid & ~w_done;
            up_wready  = s.wready & ~w_done;
            aw_hs      = sel_awvalid & s.awready & ~aw_done;
            w_hs       = sel_wvalid & s.wready & ~w_done;
            if ((aw_done | aw_hs) & (w_done | w_hs)) state_d = WR_RESP;
         end
         WR_RESP: begin
            s.bready  = sel_bready;
            up_bvalid = s.bvalid;
            if (s.bvalid & sel_bready) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         RD_REQ: begin
            s.arvalid  = sel_arvalid;
            up_arready = s.arready;
            if (sel_arvalid & s.arready) state_d = RD_RESP;
         end
         RD_RESP: begin
            s.rready  = sel_rready;
            up_rvalid = s.rvalid;
            if (s.rvalid & sel_rready) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
`ifdef AXIL_ARB_TIMEOUT_EN
         ERR_RESP: begin
            up_bvalid = is_wr;
            up_rvalid = ~is_wr;
            up_bresp  = 2'b10;
            up_rresp  = 2'b10;
            up_rdata  = '0;
            if (is_wr ? sel_bready : sel_rready) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
`ifdef AXIL_ARB_TIMEOUT_EN
      if (tmo_hit) begin
         s.awvalid  = 1'b0;
         s.wvalid   = 1'b0;
         s.bready   = 1'b0;
         s.arvalid  = 1'b0;
         s.rready   = 1'b0;
         up_awready = 1'b0;
         up_wready  = 1'b0;
         up_bvalid  = 1'b0;
         up_arready = 1'b0;
         up_rvalid  = 1'b0;
         aw_hs      = 1'b0;
         w_hs       = 1'b0;
         done       = 1'b0;
         state_d    = ERR_RESP;
      end
`endif
   end

   always_ff @(posedge axi_lite_aclk or posedge axi_lite_reset) begin
      if (axi_lite_reset) begin
         owner   <= 1'b0;
         rr_ptr  <= 1'b0;
         is_wr   <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         if (state_q == IDLE && state_d != IDLE) begin
            owner <= win;
            is_wr <= win_aw;
         end
         if (done) rr_ptr <= ~owner;
         aw_done <= (state_q == WR_REQ) && (state_d == WR_REQ) && (aw_done || aw_hs);
         w_done  <= (state_q == WR_REQ) && (state_d == WR_REQ) && (w_done || w_hs);
      end
   end

   assign m0.awready = ~owner & up_awready;
   assign m1.awready =  owner & up_awready;
   assign m0.wready  = ~owner & up_wready;
   assign m1.wready  =  owner & up_wready;
   assign m0.bvalid  = ~owner & up_bvalid;
   assign m1.bvalid  =  owner & up_bvalid;
   assign m0.arready = ~owner & up_arready;
   assign m1.arready =  owner & up_arready;
   assign m0.rvalid  = ~owner & up_rvalid;
   assign m1.rvalid  =  owner & up_rvalid;
   assign m0.bresp   = up_bresp;
   assign m1.bresp   = up_bresp;
   assign m0.rresp   = up_rresp;
   assign m1.rresp   = up_rresp;
   assign m0.rdata   = up_rdata;
   assign m1.rdata   = up_rdata;

endmodule

// File: tb/tb_axi_lite_arb_2to1.sv
// tb/tb_axi_lite_arb_2to1.sv - directed bench for the 2:1 AXI-Lite arbiter
module tb_axi_lite_arb_2to1;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] grant;
   logic       timeout;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         w_hs_cnt = 0;
   int         tmo_pulses = 0;
   int         w0;

   axi_lite_inf #(.ASIZE(32), .DSIZE(32)) m0_if ();
   axi_lite_inf #(.ASIZE(32), .DSIZE(32)) m1_if ();
   axi_lite_inf #(.ASIZE(32), .DSIZE(32)) s_if ();

   axi_lite_arb_2to1 #(.ASIZE(32), .DSIZE(32), .TIMEOUT_CYCLES(8)) dut (
      .axi_lite_aclk  (clk),
      .axi_lite_reset (rst),
      .m0             (m0_if),
      .m1             (m1_if),
      .s              (s_if),
      .grant          (grant),
      .timeout        (timeout)
   );

   always #5 clk = ~clk;

   // Mid-cycle view of the bus equals what the next rising edge will capture.
   always @(negedge clk) begin
      if (s_if.wvalid && s_if.wready) w_hs_cnt++;
      if (timeout) tmo_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   initial begin
      m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.wvalid = 0; m0_if.wdata = 0; m0_if.wstrb = 4'hF;
      m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.bready = 1; m0_if.rready = 1;
      m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.wvalid = 0; m1_if.wdata = 0; m1_if.wstrb = 4'hF;
      m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.bready = 1; m1_if.rready = 1;
      s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = 0;
      s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = 0; s_if.rresp = 0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      samp();
      check("rst_grant", {30'd0, grant}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_s_valids", {29'd0, s_if.awvalid, s_if.wvalid, s_if.arvalid}, 32'd0);
      check("rst_s_readies", {30'd0, s_if.bready, s_if.rready}, 32'd0);
      check("rst_m0_up", {27'd0, m0_if.awready, m0_if.wready, m0_if.arready, m0_if.bvalid, m0_if.rvalid}, 32'd0);

      // Contention: both read, m0 first; m0 re-requests so the flipped pointer picks m1.
      step(); s_if.arready = 1;
      m0_if.arvalid = 1; m0_if.araddr = 32'h100;
      m1_if.arvalid = 1; m1_if.araddr = 32'h200;
      samp(); check("ct_c0_grant", {30'd0, grant}, 32'd0);
      step(); samp();
      check("ct_a_grant", {30'd0, grant}, 32'd1);
      check("ct_a_araddr", s_if.araddr, 32'h100);
      check("ct_a_arready", {30'd0, m0_if.arready, m1_if.arready}, 32'd2);
      step(); m0_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h1111_0000;
      samp();
      check("ct_a_rvalid", {30'd0, m0_if.rvalid, m1_if.rvalid}, 32'd2);
      check("ct_a_rdata", m0_if.rdata, 32'h1111_0000);
      check("ct_a_s_rready", {31'd0, s_if.rready}, 32'd1);
      step(); s_if.rvalid = 0; m0_if.arvalid = 1; m0_if.araddr = 32'h104;
      samp(); check("ct_dead_grant", {30'd0, grant}, 32'd0);
      step(); samp();
      check("ct_b_grant", {30'd0, grant}, 32'd2);
      check("ct_b_araddr", s_if.araddr, 32'h200);
      check("ct_b_arready", {30'd0, m0_if.arready, m1_if.arready}, 32'd1);
      step(); m1_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h2222_0000;
      samp();
      check("ct_b_rvalid", {30'd0, m0_if.rvalid, m1_if.rvalid}, 32'd1);
      check("ct_b_rdata", m1_if.rdata, 32'h2222_0000);
      step(); s_if.rvalid = 0;
      samp(); check("ct_b_idle", {30'd0, grant}, 32'd0);
      step(); samp();
      check("ct_c_grant", {30'd0, grant}, 32'd1);
      check("ct_c_araddr", s_if.araddr, 32'h104);
      step(); m0_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h3333_0000;
      samp(); check("ct_c_rdata", m0_if.rdata, 32'h3333_0000);
      step(); s_if.rvalid = 0; s_if.arready = 0;
      samp(); check("ct_c_idle", {30'd0, grant}, 32'd0);

      // Single write, slave ready at once.
      step(); s_if.awready = 1; s_if.wready = 1;
      m0_if.awvalid = 1; m0_if.awaddr = 32'h10; m0_if.wvalid = 1; m0_if.wdata = 32'hA5A5_A5A5;
      samp();
      check("wr_c0_grant", {30'd0, grant}, 32'd0);
      check("wr_c0_awvalid", {31'd0, s_if.awvalid}, 32'd0);
      step(); samp();
      check("wr_grant", {30'd0, grant}, 32'd1);
      check("wr_s_valids", {30'd0, s_if.awvalid, s_if.wvalid}, 32'd3);
      check("wr_s_awaddr", s_if.awaddr, 32'h10);
      check("wr_s_wdata", s_if.wdata, 32'hA5A5_A5A5);
      check("wr_m0_readies", {30'd0, m0_if.awready, m0_if.wready}, 32'd3);
      check("wr_m1_readies", {30'd0, m1_if.awready, m1_if.wready}, 32'd0);
      step(); m0_if.awvalid = 0; m0_if.wvalid = 0; s_if.bvalid = 1; s_if.bresp = 2'b00;
      samp();
      check("wr_m0_bvalid", {31'd0, m0_if.bvalid}, 32'd1);
      check("wr_m0_bresp", {30'd0, m0_if.bresp}, 32'd0);
      check("wr_s_bready", {31'd0, s_if.bready}, 32'd1);
      step(); s_if.bvalid = 0;
      samp();
      check("wr_end_grant", {30'd0, grant}, 32'd0);
      check("wr_end_timeout", {31'd0, timeout}, 32'd0);

      // W accepted before AW; W held high by the master must not be re-forwarded.
      step(); s_if.awready = 0; s_if.wready = 0; w0 = w_hs_cnt;
      m0_if.awvalid = 1; m0_if.awaddr = 32'h20; m0_if.wvalid = 1; m0_if.wdata = 32'h5A5A_0001;
      samp();
      step(); s_if.wready = 1;
      samp();
      check("wba_w_fwd", {30'd0, s_if.wvalid, m0_if.wready}, 32'd3);
      check("wba_aw_wait", {31'd0, m0_if.awready}, 32'd0);
      step(); samp();
      check("wba_w_blocked", {30'd0, s_if.wvalid, m0_if.wready}, 32'd0);
      check("wba_aw_pending", {29'd0, s_if.awvalid, grant}, 32'd5);
      step(); samp();
      check("wba_still_wr", {30'd0, grant}, 32'd1);
      step(); s_if.awready = 1;
      samp(); check("wba_aw_hs", {30'd0, s_if.awvalid, m0_if.awready}, 32'd3);
      step(); m0_if.awvalid = 0; m0_if.wvalid = 0; s_if.bvalid = 1; s_if.bresp = 2'b01;
      samp();
      check("wba_bvalid", {31'd0, m0_if.bvalid}, 32'd1);
      check("wba_bresp", {30'd0, m0_if.bresp}, 32'd1);
      check("wba_w_count", w_hs_cnt - w0, 32'd1);
      step(); s_if.bvalid = 0; s_if.bresp = 0;
      samp(); check("wba_idle", {30'd0, grant}, 32'd0);

      // m1 raises AW and AR together: write first, read after a fresh arbitration.
      step(); s_if.awready = 1; s_if.wready = 1; s_if.arready = 1;
      m1_if.awvalid = 1; m1_if.awaddr = 32'h30; m1_if.wvalid = 1; m1_if.wdata = 32'h77;
      m1_if.arvalid = 1; m1_if.araddr = 32'h34;
      samp();
      step(); samp();
      check("pri_grant", {30'd0, grant}, 32'd2);
      check("pri_wr_first", {30'd0, s_if.awvalid, s_if.arvalid}, 32'd2);
      check("pri_awaddr", s_if.awaddr, 32'h30);
      check("pri_no_arready", {31'd0, m1_if.arready}, 32'd0);
      step(); m1_if.awvalid = 0; m1_if.wvalid = 0; s_if.bvalid = 1;
      samp(); check("pri_bvalid", {30'd0, m0_if.bvalid, m1_if.bvalid}, 32'd1);
      step(); s_if.bvalid = 0;
      samp(); check("pri_dead", {30'd0, grant}, 32'd0);
      step(); samp();
      check("pri_rd", {29'd0, s_if.arvalid, grant}, 32'd6);
      check("pri_araddr", s_if.araddr, 32'h34);
      step(); m1_if.arvalid = 0; s_if.rvalid = 1; s_if.rdata = 32'h4444_4444;
      samp(); check("pri_rdata", m1_if.rdata, 32'h4444_4444);
      step(); s_if.rvalid = 0;
      samp(); check("pri_idle", {30'd0, grant}, 32'd0);

      // Reset while waiting for R: everything drops before the next edge.
      step(); m0_if.arvalid = 1; m0_if.araddr = 32'h40;
      samp();
      step(); samp();
      step(); m0_if.arvalid = 0;
      samp(); check("rst_mid_rready_pre", {31'd0, s_if.rready}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_s", {27'd0, s_if.awvalid, s_if.wvalid, s_if.arvalid, s_if.bready, s_if.rready}, 32'd0);
      check("rst_mid_grant", {30'd0, grant}, 32'd0);
      check("rst_mid_m0", {31'd0, m0_if.rvalid}, 32'd0);
      step(); rst = 1'b0; s_if.arready = 0; s_if.awready = 0; s_if.wready = 0;
      samp(); check("rst_mid_after", {30'd0, grant}, 32'd0);

`ifdef AXIL_ARB_TIMEOUT_EN
      begin
         int i_hit;
         i_hit = 0;
         step(); m0_if.arvalid = 1; m0_if.araddr = 32'h50; m0_if.rready = 0; w0 = tmo_pulses;
         for (int i = 1; i <= 20; i++) begin
            step(); samp();
            if (m0_if.rvalid) begin
               i_hit = i;
               break;
            end
         end
         check("tmo_latency", i_hit, 32'd9);
         check("tmo_rresp", {30'd0, m0_if.rresp}, 32'd2);
         check("tmo_rdata", m0_if.rdata, 32'd0);
         check("tmo_pulse", {31'd0, timeout}, 32'd1);
         check("tmo_s_arvalid", {31'd0, s_if.arvalid}, 32'd0);
         step(); m0_if.arvalid = 0; m0_if.rready = 1;
         samp(); check("tmo_pulse_end", {31'd0, timeout}, 32'd0);
         step(); samp();
         check("tmo_idle", {30'd0, grant}, 32'd0);
         check("tmo_drain", {31'd0, s_if.rready}, 32'd1);
         step(); samp();
         check("tmo_drain_end", {31'd0, s_if.rready}, 32'd0);
         check("tmo_pulse_count", tmo_pulses - w0, 32'd1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
